// File: rtl/operand_fetch.sv
// Operand fetch stage: captures one decoded instruction, waits out RAW/WAW hazards
// against a pending-write scoreboard, reads the regfile and hands operands to execute.
module operand_fetch #(
  parameter int REG_WIDTH   = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int REGFILE_NUM = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_vld,
  output logic                  id_rdy,
  input  logic                  id_rs1_en,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rd_en,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  output logic                  rs1_en,
  output logic                  rs2_en,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_WIDTH-1:0]  rs1_data,
  input  logic [REG_WIDTH-1:0]  rs2_data,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]  wr_data,
  output logic                  ex_vld,
  input  logic                  ex_rdy,
  output logic [REG_WIDTH-1:0]  ex_op1,
  output logic [REG_WIDTH-1:0]  ex_op2,
  output logic                  ex_rd_en,
  output logic [REG_ADDR_W-1:0] ex_rd_addr
);

  typedef enum logic [1:0] {IDLE, CHECK, READ, HOLD} state_e;

  state_e                  state_q;
  logic [REGFILE_NUM-1:0]  sb_q, sb_d;
  logic                    rs1_used_q, rs2_used_q, rd_en_q;
  logic [REG_ADDR_W-1:0]   rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic                    issue_q, issue_d;
  logic                    rs1_en_q, rs2_en_q;
  logic                    byp1_vld_q, byp2_vld_q;
  logic [REG_WIDTH-1:0]    byp1_q, byp2_q;
  logic                    id_rdy_q, ex_vld_q, ex_rd_en_q;
  logic [REG_WIDTH-1:0]    ex_op1_q, ex_op2_q;
  logic [REG_ADDR_W-1:0]   ex_rd_addr_q;

  logic                    capture;
  logic                    n_rs1_used, n_rs2_used, n_rd_en;
  logic [REG_ADDR_W-1:0]   n_rs1_addr, n_rs2_addr, n_rd_addr;
  logic [REG_WIDTH-1:0]    op1_sel, op2_sel;

  function automatic logic hazard_f(
    input logic [REGFILE_NUM-1:0] sb,
    input logic                   u1,
    input logic [REG_ADDR_W-1:0]  a1,
    input logic                   u2,
    input logic [REG_ADDR_W-1:0]  a2,
    input logic                   ud,
    input logic [REG_ADDR_W-1:0]  ad
  );
    return (u1 && (a1 != '0) && sb[a1]) ||
           (u2 && (a2 != '0) && sb[a2]) ||
           (ud && (ad != '0) && sb[ad]);
  endfunction

  // Read enables are registered, so the issue decision for the next cycle is made
  // against the scoreboard and instruction fields as they will be after this edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    capture    = (state_q == IDLE) && id_vld && !flush;
    n_rs1_used = capture ? id_rs1_en   : rs1_used_q;
    n_rs2_used = capture ? id_rs2_en   : rs2_used_q;
    n_rd_en    = capture ? id_rd_en    : rd_en_q;
    n_rs1_addr = capture ? id_rs1_addr : rs1_addr_q;
    n_rs2_addr = capture ? id_rs2_addr : rs2_addr_q;
    n_rd_addr  = capture ? id_rd_addr  : rd_addr_q;

    sb_d = sb_q;
    if (wr_en) sb_d[wr_addr] = 1'b0;
    // The set is applied after the clear so a same-address set wins.
    if ((state_q == READ) && !flush && rd_en_q && (rd_addr_q != '0)) sb_d[rd_addr_q] = 1'b1;
    sb_d[0] = 1'b0;

    issue_d = (capture || ((state_q == CHECK) && !issue_q && !flush)) &&
              !hazard_f(sb_d, n_rs1_used, n_rs1_addr, n_rs2_used, n_rs2_addr,
                        n_rd_en, n_rd_addr);

    op1_sel = '0;
    if (rs1_used_q && (rs1_addr_q != '0)) op1_sel = byp1_vld_q ? byp1_q : rs1_data;
    op2_sel = '0;
    if (rs2_used_q && (rs2_addr_q != '0)) op2_sel = byp2_vld_q ? byp2_q : rs2_data;
  end

  // NOTE: all state, the scoreboard included, updates with non-blocking assignments
  // and is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sb_q         <= '0;
      rs1_used_q   <= 1'b0;
      rs2_used_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      issue_q      <= 1'b0;
      rs1_en_q     <= 1'b0;
      rs2_en_q     <= 1'b0;
      byp1_vld_q   <= 1'b0;
      byp2_vld_q   <= 1'b0;
      byp1_q       <= '0;
      byp2_q       <= '0;
      id_rdy_q     <= 1'b1;
      ex_vld_q     <= 1'b0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_rd_en_q   <= 1'b0;
      ex_rd_addr_q <= '0;
    end else begin
      sb_q     <= sb_d;
      issue_q  <= issue_d;
      rs1_en_q <= issue_d && n_rs1_used;
      rs2_en_q <= issue_d && n_rs2_used;

      case (state_q)
        IDLE: begin
          if (capture) begin
            rs1_used_q <= id_rs1_en;
            rs2_used_q <= id_rs2_en;
            rd_en_q    <= id_rd_en;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rd_addr_q  <= id_rd_addr;
            id_rdy_q   <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (flush) begin
            id_rdy_q <= 1'b1;
            state_q  <= IDLE;
          end else if (issue_q) begin
            // Writeback landing in the issue cycle is missed by the regfile read.
            byp1_vld_q <= wr_en && rs1_used_q && (rs1_addr_q != '0) && (wr_addr == rs1_addr_q);
            byp2_vld_q <= wr_en && rs2_used_q && (rs2_addr_q != '0) && (wr_addr == rs2_addr_q);
            byp1_q     <= wr_data;
            byp2_q     <= wr_data;
            state_q    <= READ;
          end
        end
        READ: begin
          if (flush) begin
            id_rdy_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            ex_op1_q     <= op1_sel;
            ex_op2_q     <= op2_sel;
            ex_rd_en_q   <= rd_en_q;
            ex_rd_addr_q <= rd_addr_q;
            ex_vld_q     <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (flush || ex_rdy) begin
            ex_vld_q <= 1'b0;
            id_rdy_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          id_rdy_q <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign id_rdy     = id_rdy_q;
  assign rs1_en     = rs1_en_q;
  assign rs2_en     = rs2_en_q;
  assign rs1_addr   = rs1_addr_q;
  assign rs2_addr   = rs2_addr_q;
  assign ex_vld     = ex_vld_q;
  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_rd_en   = ex_rd_en_q;
  assign ex_rd_addr = ex_rd_addr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a phase-level reference model compared every
// cycle, plus directed scenarios with hand-computed latencies and operand values.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, id_vld, id_rdy;
  logic        id_rs1_en, id_rs2_en, id_rd_en;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        rs1_en, rs2_en;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        ex_vld, ex_rdy;
  logic [31:0] ex_op1, ex_op2;
  logic        ex_rd_en;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;

  logic [31:0] rf [32];

  operand_fetch #(.REG_WIDTH(32), .REG_ADDR_W(5), .REGFILE_NUM(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_vld(id_vld), .id_rdy(id_rdy),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Regfile: registered read (old contents on a same-edge write), write on wr_en.
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'hDEAD_0000;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    forever begin
      @(posedge clk);
      if (rs1_en) rs1_data <= rf[rs1_addr];
      if (rs2_en) rs2_data <= rf[rs2_addr];
      if (wr_en)  rf[wr_addr] <= wr_data;
    end
  end

  // Reference model: tracks which phase the instruction is in and which registers have
  // writes outstanding; operands are the architectural values seen in the issue cycle.
  logic        m_have, m_chk, m_rd, m_exv;
  logic        m_u1, m_u2, m_rde;
  logic [4:0]  m_a1, m_a2, m_rda;
  logic [31:0] m_e1, m_e2;
  logic        pend [32];
  logic [31:0] arch [32];

  initial begin
    logic blocked, iss, do_set;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_have = 0; m_chk = 0; m_rd = 0; m_exv = 0;
        for (int i = 0; i < 32; i++) begin
          pend[i] = 0;
          arch[i] = rf[i];
        end
      end else begin
        blocked = (m_u1 && m_a1 != 0 && pend[m_a1]) ||
                  (m_u2 && m_a2 != 0 && pend[m_a2]) ||
                  (m_rde && m_rda != 0 && pend[m_rda]);
        iss = m_chk && !blocked;
        check("id_rdy", id_rdy, !m_have);
        check("rs1_en", rs1_en, iss && m_u1);
        check("rs2_en", rs2_en, iss && m_u2);
        if (iss && m_u1) check("rs1_addr", rs1_addr, m_a1);
        if (iss && m_u2) check("rs2_addr", rs2_addr, m_a2);
        check("ex_vld", ex_vld, m_exv);
        if (m_exv) begin
          check("ex_op1", ex_op1, m_e1);
          check("ex_op2", ex_op2, m_e2);
          check("ex_rd_en", ex_rd_en, m_rde);
          check("ex_rd_addr", ex_rd_addr, m_rda);
        end
        do_set = 0;
        if (flush) begin
          m_have = 0; m_chk = 0; m_rd = 0; m_exv = 0;
        end else if (!m_have) begin
          if (id_vld) begin
            m_u1 = id_rs1_en; m_a1 = id_rs1_addr;
            m_u2 = id_rs2_en; m_a2 = id_rs2_addr;
            m_rde = id_rd_en; m_rda = id_rd_addr;
            m_have = 1; m_chk = 1;
          end
        end else if (m_chk) begin
          if (iss) begin
            m_e1 = (!m_u1 || m_a1 == 0) ? 32'h0 : (wr_en && wr_addr == m_a1) ? wr_data : arch[m_a1];
            m_e2 = (!m_u2 || m_a2 == 0) ? 32'h0 : (wr_en && wr_addr == m_a2) ? wr_data : arch[m_a2];
            m_chk = 0; m_rd = 1;
          end
        end else if (m_rd) begin
          m_rd = 0; m_exv = 1;
          do_set = m_rde && m_rda != 0;
        end else if (m_exv && ex_rdy) begin
          m_exv = 0; m_have = 0;
        end
        if (wr_en) begin
          pend[wr_addr] = 0;
          arch[wr_addr] = wr_data;
        end
        if (do_set) pend[m_rda] = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic u1, input logic [4:0] a1, input logic u2,
                       input logic [4:0] a2, input logic rde, input logic [4:0] rda);
    int n = 0;
    while (!id_rdy && n < 20) begin
      tick();
      n++;
    end
    check("idle_wait", id_rdy, 1'b1);
    id_rs1_en = u1; id_rs1_addr = a1;
    id_rs2_en = u2; id_rs2_addr = a2;
    id_rd_en  = rde; id_rd_addr = rda;
    id_vld    = 1'b1;
    tick();
    id_vld = 1'b0;
    t_acc  = cyc - 1;
  endtask

  task automatic wait_exv(output int lat);
    int n = 0;
    while (!ex_vld && n < 20) begin
      tick();
      n++;
    end
    check("exv_wait", ex_vld, 1'b1);
    lat = cyc - t_acc;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_id_rdy"}, id_rdy, 1'b1);
    check({tag, "_rs1_en"}, rs1_en, 1'b0);
    check({tag, "_rs2_en"}, rs2_en, 1'b0);
    check({tag, "_rs1_addr"}, rs1_addr, 5'd0);
    check({tag, "_rs2_addr"}, rs2_addr, 5'd0);
    check({tag, "_ex_vld"}, ex_vld, 1'b0);
    check({tag, "_ex_op1"}, ex_op1, 32'h0);
    check({tag, "_ex_op2"}, ex_op2, 32'h0);
    check({tag, "_ex_rd_en"}, ex_rd_en, 1'b0);
    check({tag, "_ex_rd_addr"}, ex_rd_addr, 5'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b0; flush = 1'b0; id_vld = 1'b0; ex_rdy = 1'b1;
    id_rs1_en = 0; id_rs2_en = 0; id_rd_en = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    wr_en = 1'b0; wr_addr = 0; wr_data = 0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Plain read: x3, x4, rd=x10
    issue(1, 5'd3, 1, 5'd4, 1, 5'd10);
    check("s1_rs1_en_c1", rs1_en, 1'b1);
    check("s1_rs1_addr_c1", rs1_addr, 5'd3);
    wait_exv(lat);
    check("s1_latency", lat, 3);
    check("s1_op1", ex_op1, 32'h11);
    check("s1_op2", ex_op2, 32'h22);
    check("s1_rd_en", ex_rd_en, 1'b1);
    check("s1_rd_addr", ex_rd_addr, 5'd10);
    tick();
    check("s1_rs1_en_pulse", rs1_en, 1'b0);
    wb(5'd10, 32'h1010);

    // RAW stall on x5 cleared by a writeback two cycles after acceptance
    issue(0, 5'd0, 0, 5'd0, 1, 5'd5);
    wait_exv(lat);
    tick();
    issue(1, 5'd5, 0, 5'd0, 0, 5'd0);
    check("s2_no_rs_en_c1", rs1_en, 1'b0);
    tick();
    check("s2_no_rs_en_c2", rs1_en, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hABCD;
    tick();
    wr_en = 1'b0;
    check("s2_issue_c3", rs1_en, 1'b1);
    wait_exv(lat);
    check("s2_latency", lat, 5);
    check("s2_op1", ex_op1, 32'hABCD);
    tick();

    // Same-cycle bypass: x7 written in the issue cycle, regfile returns stale 0
    issue(1, 5'd7, 0, 5'd9, 0, 5'd0);
    check("s3_issue_c1", rs1_en, 1'b1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    wait_exv(lat);
    check("s3_latency", lat, 3);
    check("s3_op1_bypass", ex_op1, 32'h55);
    check("s3_op2_unused", ex_op2, 32'h0);
    tick();

    // x0 source with garbage regfile data, rd=x0 never blocks
    issue(1, 5'd0, 1, 5'd3, 1, 5'd0);
    wait_exv(lat);
    check("s4_latency", lat, 3);
    check("s4_op1_x0", ex_op1, 32'h0);
    check("s4_op2", ex_op2, 32'h11);
    tick();
    issue(1, 5'd0, 0, 5'd0, 1, 5'd0);
    wait_exv(lat);
    check("s4_x0_no_stall", lat, 3);
    tick();

    // Back-pressure: five cycles with ex_rdy low
    ex_rdy = 1'b0;
    issue(1, 5'd3, 1, 5'd4, 0, 5'd0);
    wait_exv(lat);
    for (int i = 0; i < 5; i++) begin
      check("s5_hold_vld", ex_vld, 1'b1);
      check("s5_hold_op1", ex_op1, 32'h11);
      check("s5_hold_op2", ex_op2, 32'h22);
      check("s5_hold_id_rdy", id_rdy, 1'b0);
      tick();
    end
    ex_rdy = 1'b1;
    tick();
    check("s5_release_vld", ex_vld, 1'b0);
    check("s5_release_id_rdy", id_rdy, 1'b1);

    // Flush in READ for rd=x9: no scoreboard set, no ex_vld
    issue(0, 5'd0, 0, 5'd0, 1, 5'd9);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("s6_flush_vld", ex_vld, 1'b0);
    check("s6_flush_id_rdy", id_rdy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("s6_vld_stays_low", ex_vld, 1'b0);
      tick();
    end
    issue(1, 5'd9, 0, 5'd0, 0, 5'd0);
    wait_exv(lat);
    check("s6_sb9_clear", lat, 3);
    tick();

    // Flush in HOLD drops ex_vld
    ex_rdy = 1'b0;
    issue(1, 5'd4, 0, 5'd0, 0, 5'd0);
    wait_exv(lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("s6_hold_flush_vld", ex_vld, 1'b0);
    check("s6_hold_flush_id_rdy", id_rdy, 1'b1);

    // Asynchronous reset in the middle of HOLD
    issue(1, 5'd3, 1, 5'd4, 1, 5'd13);
    wait_exv(lat);
    check("s7_pre_reset_vld", ex_vld, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals("midhold");
    tick();
    rst = 1'b1;
    ex_rdy = 1'b1;
    tick();
    issue(1, 5'd13, 0, 5'd0, 0, 5'd0);
    wait_exv(lat);
    check("s7_sb_cleared_by_reset", lat, 3);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand fetch stage between decode and execute in the RISC-V core. It is the read-side client of the register file: it accepts one decoded instruction at a time and tracks pending destination writes in a per-register scoreboard. It stalls on RAW/WAW hazards, drives the regfile read ports, bypasses same-cycle writeback data, and hands the resolved operands to execute over a valid/ready handshake.

## Interface
Parameters:
- REG_WIDTH, 32, operand/data width in bits
- REG_ADDR_W, 5, register address width
- REGFILE_NUM, 32, number of architectural registers; x0 is hardwired zero

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the instruction in flight
- id_vld  in  1  decoded instruction valid
- id_rdy  out  1  stage can accept an instruction
- id_rs1_en, id_rs2_en  in  1 each  source operand used
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W each  source registers
- id_rd_en  in  1  instruction writes a destination
- id_rd_addr  in  REG_ADDR_W  destination register
- rs1_en, rs2_en  out  1 each  regfile read enables
- rs1_addr, rs2_addr  out  REG_ADDR_W each  regfile read addresses
- rs1_data, rs2_data  in  REG_WIDTH each  regfile read data, valid the cycle after the enable
- wr_en  in  1  writeback write enable (same net as the regfile write port)
- wr_addr  in  REG_ADDR_W  writeback address
- wr_data  in  REG_WIDTH  writeback data
- ex_vld  out  1  operands valid to execute
- ex_rdy  in  1  execute accepts
- ex_op1, ex_op2  out  REG_WIDTH each  resolved operands
- ex_rd_en  out  1  destination write flag
- ex_rd_addr  out  REG_ADDR_W  destination register

## Operation
- FSM states: IDLE, CHECK, READ, HOLD.
- IDLE: id_rdy=1. When id_vld=1, capture all id_* fields and go to CHECK.
- CHECK: a hazard exists if any of these scoreboard bits is set: used rs1, used rs2, or rd when id_rd_en=1. x0 is never a hazard.
  - Hazard present: stay in CHECK, with rs*_en=0.
  - No hazard: assert rs1_en/rs2_en for the used sources with the captured addresses, then go to READ.
  - Same-cycle bypass: in the issue cycle, if wr_en=1, wr_addr equals a used rs address, and that address is nonzero, latch wr_data as that operand's bypass value.
- READ: for each operand select, in priority order:
  - 0 if the source is unused or x0;
  - else the bypass value if latched;
  - else rsN_data.
  - Register the operands and rd fields, set sb[rd] if rd_en=1 and rd!=0, and go to HOLD.
- HOLD: ex_vld=1. On ex_rdy=1, go to IDLE. Operands and rd fields stay stable while ex_vld=1 and ex_rdy=0.
- Scoreboard (REGFILE_NUM bits, sb[0] always 0):
  - wr_en=1 clears sb[wr_addr].
  - A set in READ and a clear for the same address in the same cycle: the set wins.
- flush=1 from CHECK or READ returns the FSM to IDLE. No scoreboard set occurs and ex_vld stays 0. Writeback clears still apply.
- flush=1 in HOLD drops ex_vld and returns to IDLE. The sb bit already set stays set until its writeback.
- flush has priority over id_vld and ex_rdy.

## Timing
- Reset values: state IDLE, sb all 0, id_rdy=1, rs*_en=0, rs*_addr=0, ex_vld=0, ex_op1/op2=0, ex_rd_en=0, ex_rd_addr=0.
- No-hazard latency, from the id_vld&&id_rdy edge (cycle 0):
  - rs*_en asserted in cycle 1 (CHECK);
  - regfile data sampled in cycle 2 (READ);
  - ex_vld=1 in cycle 3.
- Minimum of 4 cycles per instruction. id_rdy=0 outside IDLE.
- Each hazard cycle adds exactly one cycle in CHECK. Issue happens in the cycle after the blocking sb bit clears.
- rs*_en is a single-cycle pulse per instruction.

## Test plan
- Reset, then instr rs1=x3, rs2=x4 with regfile x3=0x11, x4=0x22 -> ex_vld at cycle 3, ex_op1=0x11, ex_op2=0x22; ex_rd fields match the input.
- Instr rd=x5, then instr rs1=x5 -> second stalls in CHECK. wr_en x5=0xABCD two cycles later -> issue on the next cycle, ex_op1=0xABCD.
- Write x7=0x55 in the exact issue cycle of rs1=x7 while the regfile returns the stale 0x0 -> ex_op1=0x55 via bypass.
- rs1=x0 with a nonzero value on rs1_data, and rd=x0 -> ex_op1=0, no stall, sb[0] stays 0.
- Hold ex_rdy=0 for 5 cycles -> ex_vld and ex_op* stable, id_rdy=0. Assert ex_rdy -> IDLE on the next cycle.
- flush in READ for instr rd=x9 -> sb[9]=0 and ex_vld never rises. Assert rst low mid-HOLD -> all outputs return to reset values immediately.
